// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer mix path.
package eq_pkg;

  localparam int unsigned NBANDS = 5;
  localparam int unsigned GAIN_W = 12;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned SAMP_W = 16;
  localparam int unsigned FRAC   = 11;

  localparam logic [GAIN_W-1:0]        UNITY   = 12'h800;
  localparam logic signed [SAMP_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMP_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    BAND_LP,
    BAND_B1,
    BAND_B2,
    BAND_B3,
    BAND_HP
  } band_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_VOL_L,
    ST_VOL_R,
    ST_DONE
  } mix_state_e;

endpackage

// File: rtl/mix_mac.sv
// Signed operand times unsigned Q1.11 gain, floor-shifted back to integer scale.
module mix_mac
  import eq_pkg::*;
#(
  parameter int unsigned A_W = ACC_W,
  parameter int unsigned G_W = GAIN_W
) (
  input  logic signed [A_W-1:0] a,
  input  logic [G_W-1:0]        g,
  output logic signed [A_W+G_W:0] y
);

  logic signed [A_W+G_W:0] a_ext;
  logic signed [A_W+G_W:0] g_ext;
  logic signed [A_W+G_W:0] prod;

  always_comb begin
    a_ext = {{(G_W + 1){a[A_W-1]}}, a};
    g_ext = {{(A_W + 1){1'b0}}, g};
    prod  = a_ext * g_ext;
    y     = prod >>> FRAC;
  end

endmodule

// File: rtl/band_mixer.sv
// Five-band stereo mixer: per-band gain, channel sum, master volume, saturation,
// all through one shared multiplier sequenced by a small FSM.
module band_mixer
  import eq_pkg::*;
#(
  parameter int unsigned NBANDS = eq_pkg::NBANDS,
  parameter int unsigned GAIN_W = eq_pkg::GAIN_W,
  parameter int unsigned ACC_W  = eq_pkg::ACC_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NBANDS-1:0][15:0]        lft_band,
  input  logic [NBANDS-1:0][15:0]        rght_band,
  input  logic [NBANDS-1:0][GAIN_W-1:0]  band_gain,
  input  logic [GAIN_W-1:0]              volume,
  output logic [15:0]                    lft_out,
  output logic [15:0]                    rght_out,
  output logic                           vld,
  output logic                           busy
);

  localparam int unsigned PW       = ACC_W + GAIN_W + 1;
  localparam logic [3:0]  LAST_IDX = 4'(2 * NBANDS - 1);
  localparam logic signed [PW-1:0] HI = PW'(SAT_MAX);
  localparam logic signed [PW-1:0] LO = PW'(SAT_MIN);

  mix_state_e state_q, state_d;

  logic [3:0]                    idx;
  logic [NBANDS-1:0][15:0]       lft_sh, rght_sh;
  logic [NBANDS-1:0][GAIN_W-1:0] gain_sh;
  logic [GAIN_W-1:0]             vol_sh;
  logic signed [ACC_W-1:0]       acc_l, acc_r;
  logic [15:0]                   hold_l, hold_r;

  logic                    is_left;
  logic [2:0]              bsel;
  logic [15:0]             band_sel;
  logic signed [ACC_W-1:0] mul_a;
  logic [GAIN_W-1:0]       mul_g;
  logic signed [PW-1:0]    mul_y;
  logic [15:0]             sat_y;
  logic                    cap;

  // vld is still high in the first IDLE cycle after DONE; that blocks a start there.
  assign cap = (state_q == ST_IDLE) && start && !vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cap) state_d = ST_MAC;
      ST_MAC:   if (idx == LAST_IDX) state_d = ST_VOL_L;
      ST_VOL_L: state_d = ST_VOL_R;
      ST_VOL_R: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand mux for the shared multiplier.
  always_comb begin
    is_left  = idx < 4'(NBANDS);
    bsel     = is_left ? idx[2:0] : 3'(idx - 4'(NBANDS));
    band_sel = is_left ? lft_sh[bsel] : rght_sh[bsel];
    mul_a    = '0;
    mul_g    = '0;
    unique case (state_q)
      ST_MAC: begin
        mul_a = {{(ACC_W - 16){band_sel[15]}}, band_sel};
        mul_g = gain_sh[bsel];
      end
      ST_VOL_L: begin
        mul_a = acc_l;
        mul_g = vol_sh;
      end
      ST_VOL_R: begin
        mul_a = acc_r;
        mul_g = vol_sh;
      end
      default: ;
    endcase
  end

  mix_mac #(.A_W(ACC_W), .G_W(GAIN_W)) u_mac (
    .a (mul_a),
    .g (mul_g),
    .y (mul_y)
  );

  always_comb begin
    if (mul_y > HI)      sat_y = SAT_MAX;
    else if (mul_y < LO) sat_y = SAT_MIN;
    else                 sat_y = mul_y[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      lft_sh   <= '0;
      rght_sh  <= '0;
      gain_sh  <= '0;
      vol_sh   <= '0;
      acc_l    <= '0;
      acc_r    <= '0;
      hold_l   <= '0;
      hold_r   <= '0;
      lft_out  <= '0;
      rght_out <= '0;
      vld      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      vld <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cap) begin
            lft_sh  <= lft_band;
            rght_sh <= rght_band;
            gain_sh <= band_gain;
            vol_sh  <= volume;
            acc_l   <= '0;
            acc_r   <= '0;
            idx     <= '0;
            busy    <= 1'b1;
          end
        end
        ST_MAC: begin
          if (is_left) acc_l <= acc_l + mul_y[ACC_W-1:0];
          else         acc_r <= acc_r + mul_y[ACC_W-1:0];
          idx <= idx + 4'd1;
        end
        ST_VOL_L: hold_l <= sat_y;
        ST_VOL_R: hold_r <= sat_y;
        ST_DONE: begin
          lft_out  <= hold_l;
          rght_out <= hold_r;
          vld      <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
